// File: rtl/gpu_bus_writer.sv
// gpu_bus_writer: buffers CPU characters and writes each one as two nibble strobes (low then high) on the GPU bus.
// Latency: a push at edge N into an idle, empty writer drives the low nibble after N+1; CE falls after N+1+SETUP_CYCLES.
// Backpressure: WR_READY is FIFO not-full (held low during a clear); a WR_VALID while not ready is dropped.
// Optional feature macro GPU_BUS_WRITER_CLEAR_EN adds CLEAR input and FILL_CHAR for a full-framebuffer fill.
module gpu_bus_writer #(
`ifdef GPU_BUS_WRITER_CLEAR_EN
    parameter logic [7:0] FILL_CHAR = 8'h20,
`endif
    parameter int FIFO_DEPTH    = 8,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int FB_CELLS      = 8192
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef GPU_BUS_WRITER_CLEAR_EN
    input  logic        CLEAR,
`endif
    input  logic [7:0]  WR_DATA,
    input  logic        WR_VALID,
    output logic        WR_READY,
    output logic [3:0]  DATA,
    output logic        CE,
    output logic        RW,
    output logic        BUSY,
    output logic [12:0] CURSOR
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // Phase counter is wide enough for any practical bus timing (up to 255 cycles per phase).
    localparam int CW = 8;
    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [12:0]   CUR_LAST  = 13'(FB_CELLS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // Character FIFO; pointers carry an extra wrap bit to tell full from empty.
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop;
    logic [7:0]  head;

    state_t      state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic        ns, ns_nxt;
    logic [7:0]  char_q, char_nxt;
    logic [3:0]  data_q, data_nxt;
    logic        ce_q, ce_nxt;
    logic        rw_q, rw_nxt;
    logic [12:0] cursor_q, cursor_nxt;
    logic        load;
    logic [7:0]  load_char;

`ifdef GPU_BUS_WRITER_CLEAR_EN
    logic        clearing, clearing_nxt;
    logic [13:0] left, left_nxt;
    assign WR_READY = !full && !clearing;
`else
    assign WR_READY = !full;
`endif

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign push  = WR_VALID && WR_READY;

    assign DATA   = data_q;
    assign CE     = ce_q;
    assign RW     = rw_q;
    assign CURSOR = cursor_q;
    assign BUSY   = (state != IDLE) || !empty;

    // FIFO storage: written on an accepted push, contents need no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= WR_DATA;
        end
    end

    // FIFO pointers: push and pop may both occur on one edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Next-state and registered-output decode; a new character load overrides the phase logic.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ns_nxt     = ns;
        char_nxt   = char_q;
        data_nxt   = data_q;
        ce_nxt     = ce_q;
        rw_nxt     = rw_q;
        cursor_nxt = cursor_q;
        pop        = 1'b0;
        load       = 1'b0;
        load_char  = head;
`ifdef GPU_BUS_WRITER_CLEAR_EN
        clearing_nxt = clearing;
        left_nxt     = left;
`endif
        case (state)
            IDLE: begin
                ce_nxt = 1'b1;
`ifdef GPU_BUS_WRITER_CLEAR_EN
                if (CLEAR && empty) begin
                    clearing_nxt = 1'b1;
                    left_nxt     = 14'(FB_CELLS);
                    load         = 1'b1;
                    load_char    = FILL_CHAR;
                end else
`endif
                if (!empty) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end else begin
                    rw_nxt = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = STROBE;
                    cnt_nxt   = STROBE_LD;
                    ce_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            STROBE: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                    ce_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt != CNT_ONE) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (!ns) begin
                    ns_nxt    = 1'b1;
                    data_nxt  = char_q[7:4];
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end else begin
                    cursor_nxt = (cursor_q == CUR_LAST) ? 13'd0 : cursor_q + 13'd1;
`ifdef GPU_BUS_WRITER_CLEAR_EN
                    if (clearing && left != 14'd1) begin
                        left_nxt  = left - 14'd1;
                        load      = 1'b1;
                        load_char = FILL_CHAR;
                    end else begin
                        clearing_nxt = 1'b0;
                        left_nxt     = 14'd0;
`endif
                        if (!empty) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            rw_nxt    = 1'b1;
                        end
`ifdef GPU_BUS_WRITER_CLEAR_EN
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            char_nxt  = load_char;
            ns_nxt    = 1'b0;
            data_nxt  = load_char[3:0];
            rw_nxt    = 1'b0;
            ce_nxt    = 1'b1;
            state_nxt = SETUP;
            cnt_nxt   = SETUP_LD;
        end
    end

    // State and output registers; reset aborts any transfer on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            ns       <= 1'b0;
            char_q   <= 8'd0;
            data_q   <= 4'd0;
            ce_q     <= 1'b1;
            rw_q     <= 1'b1;
            cursor_q <= 13'd0;
`ifdef GPU_BUS_WRITER_CLEAR_EN
            clearing <= 1'b0;
            left     <= 14'd0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ns       <= ns_nxt;
            char_q   <= char_nxt;
            data_q   <= data_nxt;
            ce_q     <= ce_nxt;
            rw_q     <= rw_nxt;
            cursor_q <= cursor_nxt;
`ifdef GPU_BUS_WRITER_CLEAR_EN
            clearing <= clearing_nxt;
            left     <= left_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_gpu_bus_writer.sv
// tb_gpu_bus_writer: directed and random character streams against a schedule-based bus model.
// Latency: every edge is compared against the expected bus state one half-cycle later.
// Backpressure: pushes are offered freely; acceptance follows the model's FIFO occupancy.
module tb_gpu_bus_writer;

    localparam int DEPTH = 8;
    localparam int SU    = 2;
    localparam int ST    = 2;
    localparam int HO    = 1;
    localparam int P     = SU + ST + HO;  // cycles per nibble
    localparam int FB    = 64;            // small framebuffer so the cursor wrap is reachable

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  WR_DATA = 8'd0;
    logic        WR_VALID = 1'b0;
    logic        WR_READY;
    logic [3:0]  DATA;
    logic        CE;
    logic        RW;
    logic        BUSY;
    logic [12:0] CURSOR;

    gpu_bus_writer #(
        .FIFO_DEPTH(DEPTH),
        .SETUP_CYCLES(SU),
        .STROBE_CYCLES(ST),
        .HOLD_CYCLES(HO),
        .FB_CELLS(FB)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .WR_DATA(WR_DATA),
        .WR_VALID(WR_VALID),
        .WR_READY(WR_READY),
        .DATA(DATA),
        .CE(CE),
        .RW(RW),
        .BUSY(BUSY),
        .CURSOR(CURSOR)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int fails   = 0;

    // Reference model: pending characters, the character on the bus and when it started.
    logic [7:0] pend_q[$];
    bit         act = 1'b0;
    int         start_t = 0;
    int         t = 0;
    logic [7:0] cur = 8'd0;
    int         cursor = 0;
    logic [3:0] last_nib = 4'd0;
    bit         last_acc = 1'b0;
    logic       e_ce = 1'b1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at edge %0d", tag, obs, exp, t);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare all outputs at the falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        bit         acc;
        int         k;
        int         j;
        logic       e_rw;
        logic [3:0] e_data;
        acc = r && v && (pend_q.size() < DEPTH);
        last_acc = acc;
        WR_VALID = v;
        WR_DATA  = d;
        RST      = r;
        @(posedge CLK);
        t++;
        if (!r) begin
            pend_q.delete();
            act = 1'b0;
            cursor = 0;
            last_nib = 4'd0;
        end else begin
            if (act && t == start_t + 2 * P) begin
                act = 1'b0;
                cursor = (cursor + 1) % FB;
            end
            if (!act && pend_q.size() > 0) begin
                cur = pend_q.pop_front();
                act = 1'b1;
                start_t = t;
            end
            if (acc) pend_q.push_back(d);
        end
        if (act) begin
            k = t - start_t;
            j = k % P;
            e_data = (k < P) ? cur[3:0] : cur[7:4];
            last_nib = e_data;
            e_ce = !(j >= SU && j < SU + ST);
            e_rw = 1'b0;
        end else begin
            e_data = last_nib;
            e_ce = 1'b1;
            e_rw = 1'b1;
        end
        @(negedge CLK);
        chk("ce", 16'(CE), 16'(e_ce));
        chk("rw", 16'(RW), 16'(e_rw));
        chk("data", 16'(DATA), 16'(e_data));
        chk("busy", 16'(BUSY), 16'(act || pend_q.size() != 0));
        chk("wr_ready", 16'(WR_READY), 16'(pend_q.size() < DEPTH));
        chk("cursor", 16'(CURSOR), 16'(cursor));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((act || pend_q.size() != 0) && n < 400) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        step(1'b0, 8'h00, 1'b1);
        chk("drain_busy", 16'(BUSY), 16'd0);
    endtask

    initial begin
        int n;
        int acc_cnt;
        int need;
        int c0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        chk("reset_ce", 16'(CE), 16'd1);
        chk("reset_rw", 16'(RW), 16'd1);
        chk("reset_ready", 16'(WR_READY), 16'd1);
        step(1'b0, 8'h00, 1'b1);

        // Single character: low nibble 5 then high nibble A.
        step(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
        chk("single_cursor", 16'(CURSOR), 16'd1);

        // Back-to-back characters with no idle gap.
        c0 = cursor;
        step(1'b1, 8'h12, 1'b1);
        step(1'b1, 8'h34, 1'b1);
        step(1'b1, 8'h56, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b1);
        chk("b2b_cursor", 16'(CURSOR), 16'((c0 + 3) % FB));

        // Hold WR_VALID high until the FIFO fills; later pushes are dropped.
        for (int i = 0; i < 25; i++) step(1'b1, 8'(i * 7 + 3), 1'b1);
        chk("full_ready", 16'(WR_READY), 16'd0);
        drain();

        // Random sparse stream.
        for (int i = 0; i < 300; i++) step(($urandom_range(0, 2) == 0), 8'($urandom), 1'b1);
        drain();

        // Cursor wrap: bring the cursor to FB-1, then one more character wraps it to 0.
        need = FB - 1 - cursor;
        acc_cnt = 0;
        n = 0;
        while (acc_cnt < need && n < 5000) begin
            step(1'b1, 8'($urandom), 1'b1);
            if (last_acc) acc_cnt++;
            n++;
        end
        drain();
        chk("cursor_pre_wrap", 16'(CURSOR), 16'(FB - 1));
        step(1'b1, 8'h41, 1'b1);
        drain();
        chk("cursor_wrap", 16'(CURSOR), 16'd0);

        // Reset while CE is low, then a fresh character starts from its low nibble.
        step(1'b1, 8'h7E, 1'b1);
        step(1'b1, 8'h99, 1'b1);
        n = 0;
        while (e_ce !== 1'b0 && n < 20) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("mid_strobe_ce", 16'(CE), 16'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("rst_ce", 16'(CE), 16'd1);
        chk("rst_busy", 16'(BUSY), 16'd0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h3C, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("restart_low_nibble", 16'(DATA), 16'h000C);
        drain();
        chk("restart_cursor", 16'(CURSOR), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
